// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the raster generator: default 640x480@60 timing,
// test pattern encodings, raster phase states, bar colours and the phase
// stepping helper used by both the horizontal and vertical FSMs.
// No ports (package).
// ---------------------------------------------------------------------------
package video_pkg;

   // Default 640x480@60 timing (25.175 MHz pixel clock)
   localparam int VID_H_ACTIVE = 640;
   localparam int VID_H_FP     = 16;
   localparam int VID_H_SYNC   = 96;
   localparam int VID_H_BP     = 48;
   localparam int VID_V_ACTIVE = 480;
   localparam int VID_V_FP     = 10;
   localparam int VID_V_SYNC   = 2;
   localparam int VID_V_BP     = 33;
   localparam logic VID_HSYNC_POL = 1'b0;
   localparam logic VID_VSYNC_POL = 1'b0;

   // Test pattern select encodings
   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_GRAD  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_SOLID = 2'd3
   } pattern_t;

   // Phase of one raster axis
   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_t;

   // Colour bar palette, {r,g,b}, left to right
   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   // Phase the axis enters when its counter takes the value cnt_next.
   // Each phase boundary is a single counter value, so the phase only
   // changes on those compares and otherwise holds.
   function automatic phase_t next_phase(
      input logic [11:0] cnt_next,
      input phase_t      cur,
      input logic [11:0] fp_start,
      input logic [11:0] sync_start,
      input logic [11:0] bp_start
   );
      phase_t nxt;
      nxt = cur;
      if (cnt_next == 12'd0)
         nxt = PH_ACTIVE;
      else if (cnt_next == fp_start)
         nxt = PH_FP;
      else if (cnt_next == sync_start)
         nxt = PH_SYNC;
      else if (cnt_next == bp_start)
         nxt = PH_BP;
      return nxt;
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// ---------------------------------------------------------------------------
// video_timing_gen_if
// Raster output bundle from the timing generator to the colour output
// stages. master = generator side (drives), slave = consumer side.
//   red/green/blue  8-bit pixel components
//   blanking        high outside the active area
//   hsync/vsync     sync pulses at the configured polarity
//   x/y             position of the pixel currently presented
//   frame_start     one-cycle pulse with pixel (0,0)
// ---------------------------------------------------------------------------
interface video_timing_gen_if;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        blanking;
   logic        hsync;
   logic        vsync;
   logic [11:0] x;
   logic [11:0] y;
   logic        frame_start;

   modport master (
      output red, green, blue, blanking, hsync, vsync, x, y, frame_start
   );

   modport slave (
      input red, green, blue, blanking, hsync, vsync, x, y, frame_start
   );
endinterface

// File: rtl/pattern_gen.sv
// ---------------------------------------------------------------------------
// pattern_gen
// Combinational test pattern colour for one pixel. Blanking is applied by
// the caller, so this block assumes the pixel is inside the active area.
//   x          horizontal position (12 bits)
//   y          low byte of vertical position
//   frame_cnt  8-bit frame counter (gradient blue)
//   pattern    frame-latched pattern select
//   solid_rgb  frame-latched {r,g,b} for the solid pattern
//   rgb        {r,g,b} colour out
// ---------------------------------------------------------------------------
module pattern_gen
   import video_pkg::*;
#(
   parameter int H_ACTIVE = VID_H_ACTIVE
)(
   input  logic [11:0] x,
   input  logic [7:0]  y,
   input  logic [7:0]  frame_cnt,
   input  pattern_t    pattern,
   input  logic [23:0] solid_rgb,
   output logic [23:0] rgb
);

   // Guard against a zero bar width for very narrow test rasters
   localparam int          BAR_W_INT = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
   localparam logic [11:0] BAR_W     = 12'(BAR_W_INT);

   logic [11:0] bar_idx;
   logic [23:0] bar_rgb;

   // Which of the eight bars x falls in; anything past the last bar is black
   always_comb begin
      bar_idx = x / BAR_W;
      case (bar_idx)
         12'd0:   bar_rgb = BAR_WHITE;
         12'd1:   bar_rgb = BAR_YELLOW;
         12'd2:   bar_rgb = BAR_CYAN;
         12'd3:   bar_rgb = BAR_GREEN;
         12'd4:   bar_rgb = BAR_MAGENTA;
         12'd5:   bar_rgb = BAR_RED;
         12'd6:   bar_rgb = BAR_BLUE;
         default: bar_rgb = BAR_BLACK;
      endcase
   end

   // Select the colour for the latched pattern
   always_comb begin
      rgb = 24'h000000;
      case (pattern)
         PAT_BARS:  rgb = bar_rgb;
         PAT_GRAD:  rgb = {x[7:0], y, frame_cnt};
         PAT_CHECK: rgb = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
         PAT_SOLID: rgb = solid_rgb;
         default:   rgb = 24'h000000;
      endcase
   end

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Pixel-clock raster generator: h/v counters, phase FSMs, sync, blanking
// and test pattern, all presented through one output register stage.
//   clk          pixel clock
//   rst          asynchronous reset, active low
//   pattern_sel  test pattern select, sampled at the frame boundary
//   solid_rgb    {r,g,b} for the solid pattern, sampled with pattern_sel
//   vid          raster output bundle (master side)
// H_TOTAL and V_TOTAL must both stay below 4096 (12-bit counters).
// ---------------------------------------------------------------------------
module video_timing_gen
   import video_pkg::*;
#(
   parameter int   H_ACTIVE  = VID_H_ACTIVE,
   parameter int   H_FP      = VID_H_FP,
   parameter int   H_SYNC    = VID_H_SYNC,
   parameter int   H_BP      = VID_H_BP,
   parameter int   V_ACTIVE  = VID_V_ACTIVE,
   parameter int   V_FP      = VID_V_FP,
   parameter int   V_SYNC    = VID_V_SYNC,
   parameter int   V_BP      = VID_V_BP,
   parameter logic HSYNC_POL = VID_HSYNC_POL,
   parameter logic VSYNC_POL = VID_VSYNC_POL
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         pattern_sel,
   input  logic [23:0]        solid_rgb,
   video_timing_gen_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_MAX        = 12'(H_TOTAL - 1);
   localparam logic [11:0] H_FP_START   = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_BP_START   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] V_MAX        = 12'(V_TOTAL - 1);
   localparam logic [11:0] V_FP_START   = 12'(V_ACTIVE);
   localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_BP_START   = 12'(V_ACTIVE + V_FP + V_SYNC);

   logic [11:0] h_cnt, h_next;
   logic [11:0] v_cnt, v_next;
   logic        h_wrap, v_wrap;
   phase_t      h_phase, h_phase_next;
   phase_t      v_phase, v_phase_next;
   logic [7:0]  frame_cnt;
   logic        at_origin;
   logic        active;
   pattern_t    pat_latch, pat_eff;
   logic [23:0] solid_latch, solid_eff;
   logic [23:0] pat_rgb;

   // Next counter values and next phases. The vertical axis only steps on
   // the horizontal wrap, so its phase follows whole lines.
   always_comb begin
      h_wrap       = (h_cnt == H_MAX);
      v_wrap       = (v_cnt == V_MAX);
      h_next       = h_wrap ? 12'd0 : h_cnt + 12'd1;
      v_next       = v_cnt;
      v_phase_next = v_phase;
      if (h_wrap) begin
         v_next       = v_wrap ? 12'd0 : v_cnt + 12'd1;
         v_phase_next = next_phase(v_next, v_phase, V_FP_START, V_SYNC_START, V_BP_START);
      end
      h_phase_next = next_phase(h_next, h_phase, H_FP_START, H_SYNC_START, H_BP_START);
   end

   // Counter and phase state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt   <= 12'd0;
         v_cnt   <= 12'd0;
         h_phase <= PH_ACTIVE;
         v_phase <= PH_ACTIVE;
      end else begin
         h_cnt   <= h_next;
         v_cnt   <= v_next;
         h_phase <= h_phase_next;
         v_phase <= v_phase_next;
      end
   end

   // Frame counter for the gradient pattern; steps when the whole raster wraps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         frame_cnt <= 8'd0;
      else if (h_wrap && v_wrap)
         frame_cnt <= frame_cnt + 8'd1;
   end

   // Pattern controls are taken at the origin and bypassed straight through
   // for that pixel, so the whole frame, (0,0) included, uses one setting.
   always_comb begin
      at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
      pat_eff   = at_origin ? pattern_t'(pattern_sel) : pat_latch;
      solid_eff = at_origin ? solid_rgb : solid_latch;
      active    = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
   end

   // Frame-boundary latch of the pattern controls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_latch   <= PAT_BARS;
         solid_latch <= 24'h000000;
      end else if (at_origin) begin
         pat_latch   <= pattern_t'(pattern_sel);
         solid_latch <= solid_rgb;
      end
   end

   pattern_gen #(
      .H_ACTIVE (H_ACTIVE)
   ) u_pattern (
      .x         (h_cnt),
      .y         (v_cnt[7:0]),
      .frame_cnt (frame_cnt),
      .pattern   (pat_eff),
      .solid_rgb (solid_eff),
      .rgb       (pat_rgb)
   );

   // Single output register stage: everything presented after an edge
   // describes the counter state held before that edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vid.red         <= 8'h00;
         vid.green       <= 8'h00;
         vid.blue        <= 8'h00;
         vid.blanking    <= 1'b1;
         vid.hsync       <= ~HSYNC_POL;
         vid.vsync       <= ~VSYNC_POL;
         vid.x           <= 12'd0;
         vid.y           <= 12'd0;
         vid.frame_start <= 1'b0;
      end else begin
         vid.red         <= active ? pat_rgb[23:16] : 8'h00;
         vid.green       <= active ? pat_rgb[15:8]  : 8'h00;
         vid.blue        <= active ? pat_rgb[7:0]   : 8'h00;
         vid.blanking    <= ~active;
         vid.hsync       <= (h_phase == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
         vid.vsync       <= (v_phase == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
         vid.x           <= h_cnt;
         vid.y           <= v_cnt;
         vid.frame_start <= at_origin;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
// Self-checking bench for video_timing_gen on a reduced raster
// (16+1+2+1 pixels by 9+1+1+1 lines, 240 pixels per frame) so that more than
// 256 frames fit in a short run. A pixel-index reference model predicts every
// output on every cycle; a vector table and hand-written sequences cover
// specific pixels, timing counts, frame-boundary pattern changes and reset.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;
   import video_pkg::*;

   localparam int HA = 16, HFP = 1, HS = 2, HBP = 1;
   localparam int VA = 9,  VFP = 1, VS = 1, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam bit HPOL = 1'b0;
   localparam bit VPOL = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  pattern_sel = 2'd0;
   logic [23:0] solid_rgb = 24'h0;

   video_timing_gen_if vid();

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pattern_sel (pattern_sel),
      .solid_rgb   (solid_rgb),
      .vid         (vid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;
   logic [1:0]  cur_sel = 2'd0;
   logic [23:0] cur_solid = 24'h0;

   logic [51:0] dut_bundle;
   logic [51:0] exp_bundle;
   localparam logic [51:0] RESET_BUNDLE = {24'h0, 1'b1, !HPOL, !VPOL, 12'd0, 12'd0, 1'b0};

   assign dut_bundle = {vid.red, vid.green, vid.blue, vid.blanking, vid.hsync,
                        vid.vsync, vid.x, vid.y, vid.frame_start};

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL timeout waiting for %s", name);
   endtask

   // Expected {rgb, blanking, hsync, vsync} of one pixel, from its position
   function automatic logic [26:0] pixel_model(input int px, input int py,
         input logic [1:0] pat, input logic [23:0] solid, input int fc);
      logic [23:0] bars [8];
      logic [23:0] rgb;
      logic blank, hs, vs;
      bars  = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      blank = !(px < HA && py < VA);
      hs    = (px >= HA + HFP && px < HA + HFP + HS) ? HPOL : !HPOL;
      vs    = (py >= VA + VFP && py < VA + VFP + VS) ? VPOL : !VPOL;
      rgb   = 24'h0;
      if (!blank) begin
         case (pat)
            2'd0: rgb = bars[px / (HA / 8)];
            2'd1: rgb = {px[7:0], py[7:0], fc[7:0]};
            2'd2: rgb = (((px / 8) % 2) != ((py / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
            default: rgb = solid;
         endcase
      end
      return {rgb, blank, hs, vs};
   endfunction

   // Reference model: a pixel index into the frame plus frame number
   int          m_pos;
   int          m_frame;
   logic [1:0]  m_pat;
   logic [23:0] m_solid;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pos      <= 0;
         m_frame    <= 0;
         m_pat      <= 2'd0;
         m_solid    <= 24'h0;
         exp_bundle <= RESET_BUNDLE;
      end else begin
         if (m_pos == 0) begin
            m_pat   <= pattern_sel;
            m_solid <= solid_rgb;
         end
         exp_bundle <= {pixel_model(m_pos % HT, m_pos / HT,
                                    (m_pos == 0) ? pattern_sel : m_pat,
                                    (m_pos == 0) ? solid_rgb : m_solid, m_frame),
                        12'(m_pos % HT), 12'(m_pos / HT), (m_pos == 0)};
         m_pos <= (m_pos + 1) % FRAME;
         if (m_pos == FRAME - 1)
            m_frame <= (m_frame + 1) % 256;
      end
   end

   // Scoreboard: every output every cycle against the model
   always @(negedge clk) begin
      if (check_en)
         checkOutput("scoreboard", 64'(dut_bundle), 64'(exp_bundle));
   end

   task automatic waitFrameStart(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (vid.frame_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) reportTimeout("frame_start");
   endtask

   task automatic waitPixel(input int px, input int py, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (vid.x === 12'(px) && vid.y === 12'(py)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) reportTimeout($sformatf("pixel (%0d,%0d)", px, py));
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [23:0] solid;
      int          px;
      int          py;
      logic [23:0] rgb;
      logic [23:0] mask;
      logic        blank;
      logic        hs;
      logic        vs;
   } vec_t;

   // Switch pattern at a frame boundary if needed, then go to the pixel
   task automatic applyStimulus(input vec_t v, output bit ok);
      bit fs_ok;
      if (v.sel !== cur_sel || v.solid !== cur_solid) begin
         pattern_sel = v.sel;
         solid_rgb   = v.solid;
         cur_sel     = v.sel;
         cur_solid   = v.solid;
         waitFrameStart(fs_ok);
      end
      waitPixel(v.px, v.py, ok);
   endtask

   initial begin
      vec_t vecs[$];
      bit ok;
      int n, vs_low, hs_low, blank_cnt, blank_low_rows, cur_frame;

      $display("[TB] video_timing_gen bench, raster %0dx%0d, frame %0d cycles", HT, VT, FRAME);

      // Reset held low for 10 cycles
      #3 rst = 1'b0;
      #1 check_en = 1'b1;
      checkOutput("reset blanking", 64'(vid.blanking), 64'd1);
      checkOutput("reset hsync", 64'(vid.hsync), 64'(!HPOL));
      checkOutput("reset vsync", 64'(vid.vsync), 64'(!VPOL));
      checkOutput("reset colour", 64'({vid.red, vid.green, vid.blue}), 64'd0);
      checkOutput("reset frame_start", 64'(vid.frame_start), 64'd0);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("first pixel xy", 64'({vid.x, vid.y}), 64'd0);
      checkOutput("first frame_start", 64'(vid.frame_start), 64'd1);

      // Vector table in raster order per pattern
      vecs.push_back('{2'd0, 24'h0,  0,  0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0,  2,  0, 24'hFFFF00, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0, 16,  0, 24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0,  8,  1, 24'hFF00FF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0, 10,  1, 24'hFF0000, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0,  4,  2, 24'h00FFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0, 17,  2, 24'h000000, 24'hFFFFFF, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{2'd0, 24'h0, 18,  2, 24'h000000, 24'hFFFFFF, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{2'd0, 24'h0,  1,  3, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0, 12,  3, 24'h0000FF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0, 19,  4, 24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0,  6,  8, 24'h00FF00, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0, 15,  8, 24'h000000, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0,  5,  9, 24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{2'd0, 24'h0,  5, 10, 24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{2'd0, 24'h0, 17, 10, 24'h000000, 24'hFFFFFF, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{2'd0, 24'h0,  0, 11, 24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{2'd2, 24'h0,  8,  0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd2, 24'h0,  7,  0, 24'h000000, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd2, 24'h0,  7,  8, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd2, 24'h0,  8,  8, 24'h000000, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd3, 24'h123456, 5, 2, 24'h123456, 24'hFFFFFF, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd3, 24'h123456, 5, 9, 24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 1'b1});
      vecs.push_back('{2'd1, 24'h0, 13,  7, 24'h0D0700, 24'hFFFF00, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'd1, 24'h0, 16,  7, 24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 1'b1});

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], ok);
         if (ok) begin
            checkOutput($sformatf("vec%0d rgb", i),
                        64'({vid.red, vid.green, vid.blue} & vecs[i].mask),
                        64'(vecs[i].rgb & vecs[i].mask));
            checkOutput($sformatf("vec%0d blanking", i), 64'(vid.blanking), 64'(vecs[i].blank));
            checkOutput($sformatf("vec%0d hsync", i), 64'(vid.hsync), 64'(vecs[i].hs));
            checkOutput($sformatf("vec%0d vsync", i), 64'(vid.vsync), 64'(vecs[i].vs));
         end
      end

      // One full frame: period and pulse/blanking counts
      waitFrameStart(ok);
      n = 1;
      vs_low = (vid.vsync === 1'b0) ? 1 : 0;
      hs_low = (vid.hsync === 1'b0) ? 1 : 0;
      blank_cnt = (vid.blanking === 1'b1) ? 1 : 0;
      blank_low_rows = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (vid.frame_start === 1'b1) break;
         n++;
         if (vid.vsync === 1'b0) vs_low++;
         if (vid.hsync === 1'b0) hs_low++;
         if (vid.blanking === 1'b1) blank_cnt++;
         if (vid.y >= 12'(VA) && vid.blanking === 1'b1) blank_low_rows++;
      end
      checkOutput("frame_start period", 64'(n), 64'(FRAME));
      checkOutput("vsync low cycles", 64'(vs_low), 64'(HT * VS));
      checkOutput("hsync low cycles", 64'(hs_low), 64'(HS * VT));
      checkOutput("blanking cycles", 64'(blank_cnt), 64'(FRAME - HA * VA));
      checkOutput("blanking below active", 64'(blank_low_rows), 64'(HT * (VT - VA)));

      // Pattern change mid-frame takes effect only at the next frame
      pattern_sel = 2'd0;
      solid_rgb   = 24'h0;
      waitFrameStart(ok);
      waitPixel(0, 4, ok);
      pattern_sel = 2'd3;
      solid_rgb   = 24'h123456;
      waitPixel(0, 5, ok);
      checkOutput("mid-frame still bars", 64'({vid.red, vid.green, vid.blue}), 64'h00FFFFFF);
      waitPixel(12, 8, ok);
      checkOutput("mid-frame still blue bar", 64'({vid.red, vid.green, vid.blue}), 64'h000000FF);
      waitFrameStart(ok);
      checkOutput("next frame solid at origin", 64'({vid.red, vid.green, vid.blue}), 64'h00123456);
      waitPixel(15, 8, ok);
      checkOutput("next frame solid last pixel", 64'({vid.red, vid.green, vid.blue}), 64'h00123456);

      // Asynchronous reset in the middle of a frame
      waitPixel(10, 5, ok);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid reset bundle", 64'(dut_bundle), 64'(RESET_BUNDLE));
      repeat (3) @(negedge clk);
      pattern_sel = 2'd0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("restart xy", 64'({vid.x, vid.y}), 64'd0);
      checkOutput("restart frame_start", 64'(vid.frame_start), 64'd1);
      checkOutput("restart bars", 64'({vid.red, vid.green, vid.blue}), 64'h00FFFFFF);
      cur_frame = 0;

      // Random pattern/solid changes at random points in each frame
      while (cur_frame < 249) begin
         repeat ($urandom_range(1, FRAME - 20)) @(negedge clk);
         pattern_sel = 2'($urandom_range(0, 3));
         solid_rgb   = 24'($urandom);
         waitFrameStart(ok);
         if (!ok) break;
         cur_frame++;
      end

      // Gradient across the 8-bit frame counter wrap
      pattern_sel = 2'd1;
      for (int f = 0; f < 9; f++) begin
         waitFrameStart(ok);
         if (!ok) break;
         cur_frame++;
         checkOutput($sformatf("gradient origin frame %0d", cur_frame),
                     64'({vid.red, vid.green, vid.blue}), 64'(cur_frame % 256));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
